// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM and the datapath/memory.
// The FSM takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, instr_done, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, instr_done, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/mem/writeback over a
// shared-memory datapath, with memory wait states and a sticky illegal-opcode trap.
module multicycle_control_fsm #(
  parameter bit ENABLE_BEQ  = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  bus
);

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_dec;
  logic [5:0] r_opcode;

  // IR may be reloaded after DECODE, so MEMADR steers on the latched opcode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_RST;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
    end
  end

  always_comb begin
    w_dec = S_TRAP;
    case (bus.opcode)
      OP_RTYPE:     w_dec = S_EXEC;
      OP_LW, OP_SW: w_dec = S_MEMADR;
      OP_BEQ:       if (ENABLE_BEQ)  w_dec = S_BRANCH;
      OP_J:         if (ENABLE_JUMP) w_dec = S_JUMP;
      OP_ADDI:      if (ENABLE_ADDI) w_dec = S_ADDIEX;
      default:      w_dec = S_TRAP;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_dec;
      S_MEMADR: w_next = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_src        = 2'b00;
    bus.illegal_op    = 1'b0;
    bus.instr_done    = 1'b0;
    bus.state         = r_state;
    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write  = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_src        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.instr_done    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_src     = 2'b10;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_TRAP:  bus.illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed vector bench for the multicycle control FSM, plus a beq-disabled instance
// to exercise the trap path for a configured-out opcode.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst_n, rst2_n;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();
  multicycle_control_fsm_if bus2 ();

  multicycle_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  multicycle_control_fsm #(.ENABLE_BEQ(1'b0)) dut_nobeq (.clk(clk), .rst_n(rst2_n), .bus(bus2.master));

  // {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb[2], aluop[2], pcsrc[2], ill, done}
  logic [18:0] w_o;
  assign w_o = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op, bus.instr_done};

  localparam logic [18:0] O_ZERO    = 19'b0;
  localparam logic [18:0] O_FETCH_R = 19'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] O_FETCH_W = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] O_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [18:0] O_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] O_MEMRD   = 19'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] O_MEMWB   = 19'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
  localparam logic [18:0] O_MEMWR_R = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
  localparam logic [18:0] O_MEMWR_W = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] O_EXEC    = 19'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [18:0] O_ALUWB   = 19'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
  localparam logic [18:0] O_BRANCH  = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [18:0] O_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1;
  localparam logic [18:0] O_ADDIWB  = 19'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;
  localparam logic [18:0] O_TRAP    = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] o;
  } vec_t;

  vec_t tv[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [18:0] o);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st; v.o = o;
    tv.push_back(v);
  endtask

  // One vector = one clock cycle: drive after negedge, check before the next posedge.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; bus.opcode = v.op; bus.mem_ready = v.rdy;
    #1;
    nvec++;
    if (bus.state !== v.st || w_o !== v.o) begin
      nerr++;
      $display("FAIL vec%0d: state=%0d outs=%b, expected state=%0d outs=%b",
               idx, bus.state, w_o, v.st, v.o);
    end
  endtask

  task automatic step2(input string nm, input logic r, input logic [5:0] op,
                       input logic [3:0] st, input logic ill);
    @(negedge clk);
    rst2_n = r; bus2.opcode = op; bus2.mem_ready = 1'b1;
    #1;
    nvec++;
    if (bus2.state !== st || bus2.illegal_op !== ill || bus2.reg_write !== 1'b0 ||
        bus2.mem_write !== 1'b0) begin
      nerr++;
      $display("FAIL %s: state=%0d illegal_op=%b, expected state=%0d illegal_op=%b",
               nm, bus2.state, bus2.illegal_op, st, ill);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    bus.opcode = RT; bus.mem_ready = 1'b1;
    bus2.opcode = RT; bus2.mem_ready = 1'b1;

    // R-type
    add(1, RT, 1, 0, O_ZERO);
    add(1, RT, 1, 1, O_FETCH_R);
    add(1, RT, 1, 2, O_DECODE);
    add(1, BAD, 1, 7, O_EXEC);
    add(1, BAD, 1, 8, O_ALUWB);
    // lw with 3 wait cycles; opcode scrambled after DECODE
    add(1, RT, 1, 1, O_FETCH_R);
    add(1, LW, 1, 2, O_DECODE);
    add(1, SW, 1, 3, O_MEMADR);
    add(1, BAD, 0, 4, O_MEMRD);
    add(1, BAD, 0, 4, O_MEMRD);
    add(1, BAD, 0, 4, O_MEMRD);
    add(1, BAD, 1, 4, O_MEMRD);
    add(1, BAD, 0, 5, O_MEMWB);
    // sw, beq, j, addi
    add(1, RT, 1, 1, O_FETCH_R);
    add(1, SW, 1, 2, O_DECODE);
    add(1, LW, 1, 3, O_MEMADR);
    add(1, RT, 1, 6, O_MEMWR_R);
    add(1, RT, 1, 1, O_FETCH_R);
    add(1, BQ, 1, 2, O_DECODE);
    add(1, RT, 1, 9, O_BRANCH);
    add(1, RT, 1, 1, O_FETCH_R);
    add(1, JJ, 1, 2, O_DECODE);
    add(1, RT, 1, 10, O_JUMP);
    add(1, RT, 1, 1, O_FETCH_R);
    add(1, AI, 1, 2, O_DECODE);
    add(1, RT, 1, 11, O_MEMADR);
    add(1, RT, 1, 12, O_ADDIWB);
    // fetch wait state, then illegal opcode
    add(1, RT, 0, 1, O_FETCH_W);
    add(1, RT, 1, 1, O_FETCH_R);
    add(1, BAD, 1, 2, O_DECODE);
    for (int i = 0; i < 10; i++) add(1, RT, i[0], 13, O_TRAP);
    add(0, RT, 1, 13, O_TRAP);
    add(1, RT, 1, 0, O_ZERO);
    // reset in the middle of a stalled store
    add(1, RT, 1, 1, O_FETCH_R);
    add(1, SW, 1, 2, O_DECODE);
    add(1, RT, 1, 3, O_MEMADR);
    add(0, RT, 0, 6, O_MEMWR_W);
    add(1, RT, 0, 0, O_ZERO);
    add(1, RT, 0, 1, O_FETCH_W);

    // Hold reset two cycles, then check the RST state before releasing.
    @(negedge clk);
    @(negedge clk);
    #1;
    nvec++;
    if (bus.state !== 4'd0 || w_o !== O_ZERO) begin
      nerr++;
      $display("FAIL reset: state=%0d outs=%b, expected state=0 outs=%b", bus.state, w_o, O_ZERO);
    end

    for (int i = 0; i < tv.size(); i++) apply(i, tv[i]);

    // beq configured out: must trap and stay trapped
    step2("nobeq_rst", 1'b1, RT, 4'd0, 1'b0);
    step2("nobeq_fetch", 1'b1, RT, 4'd1, 1'b0);
    step2("nobeq_decode", 1'b1, BQ, 4'd2, 1'b0);
    for (int i = 0; i < 10; i++) step2("nobeq_trap", 1'b1, RT, 4'd13, 1'b1);
    step2("nobeq_trap_rst", 1'b0, RT, 4'd13, 1'b1);
    step2("nobeq_after_rst", 1'b1, RT, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
